// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS decode constants: opcodes, instruction field
//                bit positions and default datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    // Default datapath widths
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int INSTR_WIDTH        = 32;
    localparam int IMM_WIDTH          = 16;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Opcodes of interest to decode
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    // Logical immediates are zero-extended; everything else sign-extends
    function automatic logic is_zext_op(input logic [5:0] opcode);
        return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard_unit.sv
// ============================================================================
//  Module      : hazard_unit
//  Description : Combinational load-use hazard detector. Flags when the load
//                sitting in EX writes a register the IF/ID instruction reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_ex_valid,
    input  logic                      i_ex_memread,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rt,
    input  logic                      i_if_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_if_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_if_rt,
    input  logic                      i_ex_stall,
    input  logic                      i_flush,
    output logic                      o_hazard_stall
);

    logic w_load_in_ex;
    logic w_reg_match;

    // A stalled or flushed stage never bubbles: the load either holds or dies
    always_comb begin
        w_load_in_ex   = i_ex_valid && i_ex_memread && i_if_valid && (i_ex_rt != '0);
        w_reg_match    = (i_ex_rt == i_if_rs) || (i_ex_rt == i_if_rt);
        o_hazard_stall = w_load_in_ex && w_reg_match && !i_ex_stall && !i_flush;
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : Decode-to-execute pipeline register. Splits the instruction,
//                drives register-file read addresses, extends the immediate,
//                registers operands/fields for EX, and inserts counted
//                bubbles on load-use hazards.
//  Options     : ID_EX_WB_BYPASS_EN - forward same-cycle writeback data into
//                the captured operands.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      If_Valid,
    input  logic [INSTR_WIDTH-1:0]    If_Instruction,
    input  logic [DATA_WIDTH-1:0]     If_PC,
    output logic [REG_ADDR_WIDTH-1:0] Read_Register1,
    output logic [REG_ADDR_WIDTH-1:0] Read_Register2,
    input  logic [DATA_WIDTH-1:0]     Read_Data1,
    input  logic [DATA_WIDTH-1:0]     Read_Data2,
    input  logic                      Wb_RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] Wb_Write_Register,
    input  logic [DATA_WIDTH-1:0]     Wb_Write_Data,
    input  logic                      Ex_Stall,
    input  logic                      Flush,
    output logic                      Hazard_Stall,
    output logic                      Ex_Valid,
    output logic [DATA_WIDTH-1:0]     Ex_PC,
    output logic [DATA_WIDTH-1:0]     Ex_Read_Data1,
    output logic [DATA_WIDTH-1:0]     Ex_Read_Data2,
    output logic [DATA_WIDTH-1:0]     Ex_Imm,
    output logic [REG_ADDR_WIDTH-1:0] Ex_Rs,
    output logic [REG_ADDR_WIDTH-1:0] Ex_Rt,
    output logic [REG_ADDR_WIDTH-1:0] Ex_Rd,
    output logic [4:0]                Ex_Shamt,
    output logic [5:0]                Ex_Opcode,
    output logic [5:0]                Ex_Funct,
    output logic                      Ex_MemRead,
    output logic [CNT_WIDTH-1:0]      Bubble_Count
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Decoded fields
    logic [REG_ADDR_WIDTH-1:0] w_rs;
    logic [REG_ADDR_WIDTH-1:0] w_rt;
    logic [REG_ADDR_WIDTH-1:0] w_rd;
    logic [4:0]                w_shamt;
    logic [5:0]                w_opcode;
    logic [5:0]                w_funct;
    logic [IMM_WIDTH-1:0]      w_imm16;
    logic [DATA_WIDTH-1:0]     w_imm_ext;
    logic [DATA_WIDTH-1:0]     w_op1;
    logic [DATA_WIDTH-1:0]     w_op2;
    logic                      w_hazard;

    // EX-side registers
    logic                      r_ex_valid;
    logic [DATA_WIDTH-1:0]     r_ex_pc;
    logic [DATA_WIDTH-1:0]     r_ex_rd1;
    logic [DATA_WIDTH-1:0]     r_ex_rd2;
    logic [DATA_WIDTH-1:0]     r_ex_imm;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rs;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rt;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
    logic [4:0]                r_ex_shamt;
    logic [5:0]                r_ex_opcode;
    logic [5:0]                r_ex_funct;
    logic                      r_ex_memread;
    logic [CNT_WIDTH-1:0]      r_bubble_count;

    // Field split and immediate extension
    always_comb begin
        w_opcode  = If_Instruction[OPCODE_MSB:OPCODE_LSB];
        w_rs      = If_Instruction[RS_MSB:RS_LSB];
        w_rt      = If_Instruction[RT_MSB:RT_LSB];
        w_rd      = If_Instruction[RD_MSB:RD_LSB];
        w_shamt   = If_Instruction[SHAMT_MSB:SHAMT_LSB];
        w_funct   = If_Instruction[FUNCT_MSB:FUNCT_LSB];
        w_imm16   = If_Instruction[IMM_MSB:IMM_LSB];
        if (is_zext_op(w_opcode)) begin
            w_imm_ext = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, w_imm16};
        end else begin
            w_imm_ext = {{(DATA_WIDTH-IMM_WIDTH){w_imm16[IMM_WIDTH-1]}}, w_imm16};
        end
    end

    assign Read_Register1 = w_rs;
    assign Read_Register2 = w_rt;

`ifdef ID_EX_WB_BYPASS_EN
    // Operand select: writeback bypass, then $zero overrides everything
    always_comb begin
        w_op1 = Read_Data1;
        w_op2 = Read_Data2;
        if (Wb_RegWrite && (Wb_Write_Register != '0) && (Wb_Write_Register == w_rs)) begin
            w_op1 = Wb_Write_Data;
        end
        if (Wb_RegWrite && (Wb_Write_Register != '0) && (Wb_Write_Register == w_rt)) begin
            w_op2 = Wb_Write_Data;
        end
        if (w_rs == '0) begin
            w_op1 = '0;
        end
        if (w_rt == '0) begin
            w_op2 = '0;
        end
    end
`else
    // Writeback port is only meaningful when bypassing is built in
    logic w_unused_wb;
    assign w_unused_wb = ^{Wb_RegWrite, Wb_Write_Register, Wb_Write_Data};

    // Operand select: register-file data, with $zero forced to 0
    always_comb begin
        w_op1 = (w_rs == '0) ? '0 : Read_Data1;
        w_op2 = (w_rt == '0) ? '0 : Read_Data2;
    end
`endif

    hazard_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_unit (
        .i_ex_valid     (r_ex_valid),
        .i_ex_memread   (r_ex_memread),
        .i_ex_rt        (r_ex_rt),
        .i_if_valid     (If_Valid),
        .i_if_rs        (w_rs),
        .i_if_rt        (w_rt),
        .i_ex_stall     (Ex_Stall),
        .i_flush        (Flush),
        .o_hazard_stall (w_hazard)
    );

    assign Hazard_Stall = w_hazard;

    // Pipeline register update: flush > stall > bubble > capture
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= '0;
            r_ex_rd1       <= '0;
            r_ex_rd2       <= '0;
            r_ex_imm       <= '0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_rd        <= '0;
            r_ex_shamt     <= '0;
            r_ex_opcode    <= '0;
            r_ex_funct     <= '0;
            r_ex_memread   <= 1'b0;
            r_bubble_count <= '0;
        end else if (Flush) begin
            r_ex_valid <= 1'b0;
        end else if (Ex_Stall) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_hazard) begin
            // Invalidating the load ages it out, so the hazard clears next cycle
            r_ex_valid <= 1'b0;
            if (r_bubble_count != '1) begin
                r_bubble_count <= r_bubble_count + C_CNT_ONE;
            end
        end else begin
            r_ex_valid   <= If_Valid;
            r_ex_pc      <= If_PC;
            r_ex_rd1     <= w_op1;
            r_ex_rd2     <= w_op2;
            r_ex_imm     <= w_imm_ext;
            r_ex_rs      <= w_rs;
            r_ex_rt      <= w_rt;
            r_ex_rd      <= w_rd;
            r_ex_shamt   <= w_shamt;
            r_ex_opcode  <= w_opcode;
            r_ex_funct   <= w_funct;
            r_ex_memread <= (w_opcode == OP_LW);
        end
    end

    assign Ex_Valid      = r_ex_valid;
    assign Ex_PC         = r_ex_pc;
    assign Ex_Read_Data1 = r_ex_rd1;
    assign Ex_Read_Data2 = r_ex_rd2;
    assign Ex_Imm        = r_ex_imm;
    assign Ex_Rs         = r_ex_rs;
    assign Ex_Rt         = r_ex_rt;
    assign Ex_Rd         = r_ex_rd;
    assign Ex_Shamt      = r_ex_shamt;
    assign Ex_Opcode     = r_ex_opcode;
    assign Ex_Funct      = r_ex_funct;
    assign Ex_MemRead    = r_ex_memread;
    assign Bubble_Count  = r_bubble_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage with a reference model
//                and an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic        Clock;
    logic        Reset_n;
    logic        If_Valid;
    logic [31:0] If_Instruction;
    logic [31:0] If_PC;
    logic [4:0]  Read_Register1;
    logic [4:0]  Read_Register2;
    logic [31:0] Read_Data1;
    logic [31:0] Read_Data2;
    logic        Wb_RegWrite;
    logic [4:0]  Wb_Write_Register;
    logic [31:0] Wb_Write_Data;
    logic        Ex_Stall;
    logic        Flush;
    logic        Hazard_Stall;
    logic        Ex_Valid;
    logic [31:0] Ex_PC;
    logic [31:0] Ex_Read_Data1;
    logic [31:0] Ex_Read_Data2;
    logic [31:0] Ex_Imm;
    logic [4:0]  Ex_Rs;
    logic [4:0]  Ex_Rt;
    logic [4:0]  Ex_Rd;
    logic [4:0]  Ex_Shamt;
    logic [5:0]  Ex_Opcode;
    logic [5:0]  Ex_Funct;
    logic        Ex_MemRead;
    logic [15:0] Bubble_Count;

    id_ex_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .CNT_WIDTH      (16)
    ) dut (
        .Clock             (Clock),
        .Reset_n           (Reset_n),
        .If_Valid          (If_Valid),
        .If_Instruction    (If_Instruction),
        .If_PC             (If_PC),
        .Read_Register1    (Read_Register1),
        .Read_Register2    (Read_Register2),
        .Read_Data1        (Read_Data1),
        .Read_Data2        (Read_Data2),
        .Wb_RegWrite       (Wb_RegWrite),
        .Wb_Write_Register (Wb_Write_Register),
        .Wb_Write_Data     (Wb_Write_Data),
        .Ex_Stall          (Ex_Stall),
        .Flush             (Flush),
        .Hazard_Stall      (Hazard_Stall),
        .Ex_Valid          (Ex_Valid),
        .Ex_PC             (Ex_PC),
        .Ex_Read_Data1     (Ex_Read_Data1),
        .Ex_Read_Data2     (Ex_Read_Data2),
        .Ex_Imm            (Ex_Imm),
        .Ex_Rs             (Ex_Rs),
        .Ex_Rt             (Ex_Rt),
        .Ex_Rd             (Ex_Rd),
        .Ex_Shamt          (Ex_Shamt),
        .Ex_Opcode         (Ex_Opcode),
        .Ex_Funct          (Ex_Funct),
        .Ex_MemRead        (Ex_MemRead),
        .Bubble_Count      (Bubble_Count)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic        memread;
        logic [15:0] cnt;
    } exp_t;

    exp_t        m;          // reference model of the EX-side registers
    exp_t        exp_q[$];   // expected results awaiting the clock edge
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
`ifdef ID_EX_WB_BYPASS_EN
        if (Wb_RegWrite && Wb_Write_Register == r) return Wb_Write_Data;
`endif
        return rf;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, ins[15:0]};
        return {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic exp_t model_reset();
        exp_t z;
        z = '{valid: 1'b0, pc: '0, rd1: '0, rd2: '0, imm: '0, rs: '0, rt: '0, rd: '0,
              shamt: '0, opcode: '0, funct: '0, memread: 1'b0, cnt: '0};
        return z;
    endfunction

    // One clock: check combinational outputs, advance the model, check registers
    task automatic step();
        logic [4:0] rs;
        logic [4:0] rt;
        logic       haz;
        exp_t       e;
        rs  = If_Instruction[25:21];
        rt  = If_Instruction[20:16];
        haz = m.valid && m.memread && If_Valid && (m.rt != 5'd0) &&
              ((m.rt == rs) || (m.rt == rt)) && !Ex_Stall && !Flush;
        #1;
        check_val("read_reg1", Read_Register1, rs);
        check_val("read_reg2", Read_Register2, rt);
        check_val("hazard_stall", Hazard_Stall, haz);
        if (Flush) begin
            m.valid = 1'b0;
        end else if (Ex_Stall) begin
            m.valid = m.valid;
        end else if (haz) begin
            m.valid = 1'b0;
            if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        end else begin
            m.valid   = If_Valid;
            m.pc      = If_PC;
            m.rd1     = ref_operand(rs, Read_Data1);
            m.rd2     = ref_operand(rt, Read_Data2);
            m.imm     = ref_imm(If_Instruction);
            m.rs      = rs;
            m.rt      = rt;
            m.rd      = If_Instruction[15:11];
            m.shamt   = If_Instruction[10:6];
            m.opcode  = If_Instruction[31:26];
            m.funct   = If_Instruction[5:0];
            m.memread = (If_Instruction[31:26] == 6'h23);
        end
        exp_q.push_back(m);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        check_val("ex_valid",   Ex_Valid,      e.valid);
        check_val("ex_pc",      Ex_PC,         e.pc);
        check_val("ex_rd1",     Ex_Read_Data1, e.rd1);
        check_val("ex_rd2",     Ex_Read_Data2, e.rd2);
        check_val("ex_imm",     Ex_Imm,        e.imm);
        check_val("ex_rs",      Ex_Rs,         e.rs);
        check_val("ex_rt",      Ex_Rt,         e.rt);
        check_val("ex_rd",      Ex_Rd,         e.rd);
        check_val("ex_shamt",   Ex_Shamt,      e.shamt);
        check_val("ex_opcode",  Ex_Opcode,     e.opcode);
        check_val("ex_funct",   Ex_Funct,      e.funct);
        check_val("ex_memread", Ex_MemRead,    e.memread);
        check_val("bubble_cnt", Bubble_Count,  e.cnt);
        @(negedge Clock);
    endtask

    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] d1,
                       input logic [31:0] d2, input logic st, input logic fl);
        If_Valid       = v;
        If_Instruction = ins;
        If_PC          = pc_ctr;
        Read_Data1     = d1;
        Read_Data2     = d2;
        Ex_Stall       = st;
        Flush          = fl;
        pc_ctr         = pc_ctr + 32'd4;
        step();
    endtask

    localparam logic [31:0] I_ADDI   = 32'h2109FFFC; // addi $t1,$t0,-4
    localparam logic [31:0] I_ORI    = 32'h350A8000; // ori  $t2,$t0,0x8000
    localparam logic [31:0] I_ANDI   = 32'h3108FFFF; // andi $t0,$t0,0xFFFF
    localparam logic [31:0] I_XORI   = 32'h3929F00F; // xori $t1,$t1,0xF00F
    localparam logic [31:0] I_LW     = 32'h8D090000; // lw   $t1,0($t0)
    localparam logic [31:0] I_ADD    = 32'h01295020; // add  $t2,$t1,$t1
    localparam logic [31:0] I_ADDZS  = 32'h00095020; // add  $t2,$zero,$t1
    localparam logic [31:0] I_ADDZT  = 32'h01205020; // add  $t2,$t1,$zero
    localparam logic [31:0] I_ADDT0  = 32'h01085020; // add  $t2,$t0,$t0
    localparam logic [31:0] I_SLL    = 32'h000A5140; // sll  $t2,$t2,5

    initial begin
        logic [5:0]  ops [7];
        logic [31:0] ins;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0E, 6'h08};

        Reset_n = 1'b0;
        If_Valid = 1'b0; If_Instruction = '0; If_PC = '0;
        Read_Data1 = '0; Read_Data2 = '0;
        Wb_RegWrite = 1'b0; Wb_Write_Register = '0; Wb_Write_Data = '0;
        Ex_Stall = 1'b0; Flush = 1'b0;
        m = model_reset();

        repeat (2) @(negedge Clock);
        check_val("rst_ex_valid", Ex_Valid, 1'b0);
        check_val("rst_bubble",   Bubble_Count, 16'd0);
        check_val("rst_ex_pc",    Ex_PC, 32'd0);
        Reset_n = 1'b1;

        // Capture and immediate extension
        cyc(1'b1, I_ADDI, 32'h10, 32'h55, 1'b0, 1'b0);
        cyc(1'b1, I_ORI,  32'h20, 32'h66, 1'b0, 1'b0);
        cyc(1'b1, I_ANDI, 32'h30, 32'h77, 1'b0, 1'b0);
        cyc(1'b1, I_XORI, 32'h40, 32'h88, 1'b0, 1'b0);
        cyc(1'b1, I_SLL,  32'h41, 32'h99, 1'b0, 1'b0);

        // Load-use: one bubble, then the dependent add is captured
        cyc(1'b1, I_LW,  32'h100, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, I_ADD, 32'h7,   32'h7, 1'b0, 1'b0);
        cyc(1'b1, I_ADD, 32'h7,   32'h7, 1'b0, 1'b0);

        // Flush together with stall kills the entering instruction
        cyc(1'b1, I_ADDI, 32'h11, 32'h22, 1'b1, 1'b1);
        // Stall holds everything for three cycles while inputs change
        cyc(1'b1, I_ORI,  32'h12, 32'h23, 1'b0, 1'b0);
        cyc(1'b1, I_ADDI, 32'hA1, 32'hB1, 1'b1, 1'b0);
        cyc(1'b0, I_LW,   32'hA2, 32'hB2, 1'b1, 1'b0);
        cyc(1'b1, I_XORI, 32'hA3, 32'hB3, 1'b1, 1'b0);
        // Load-use pair under stall or flush never raises the hazard
        cyc(1'b1, I_LW,  32'h200, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, I_ADD, 32'h1,   32'h1, 1'b1, 1'b0);
        cyc(1'b1, I_ADD, 32'h1,   32'h1, 1'b1, 1'b0);
        cyc(1'b1, I_ADD, 32'h1,   32'h1, 1'b0, 1'b1);

        // Register zero operands and invalid-slot capture
        cyc(1'b1, I_ADDZS, 32'hDEADBEEF, 32'h5,        1'b0, 1'b0);
        cyc(1'b1, I_ADDZT, 32'h6,        32'hDEADBEEF, 1'b0, 1'b0);
        cyc(1'b0, I_ORI,   32'h9,        32'h9,        1'b0, 1'b0);

        // Writeback to $t0 while add reads $t0 with stale register-file data
        Wb_RegWrite = 1'b1; Wb_Write_Register = 5'd8; Wb_Write_Data = 32'hCAFE0001;
        cyc(1'b1, I_ADDT0, 32'h0, 32'h0, 1'b0, 1'b0);
        Wb_RegWrite = 1'b1; Wb_Write_Register = 5'd0; Wb_Write_Data = 32'h12345678;
        cyc(1'b1, I_ADDZS, 32'h0, 32'h3, 1'b0, 1'b0);
        Wb_RegWrite = 1'b0;

        // Randomised mix with a small register pool to provoke hazards
        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 6)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            Wb_RegWrite       = 1'($urandom_range(0, 1));
            Wb_Write_Register = 5'($urandom_range(0, 3));
            Wb_Write_Data     = $urandom;
            cyc(1'($urandom_range(0, 5) != 0), ins, $urandom, $urandom,
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end
        Wb_RegWrite = 1'b0;

        // Saturation: preload the counter at all-ones, then cause a hazard
        force dut.r_bubble_count = 16'hFFFF;
        #1;
        release dut.r_bubble_count;
        m.cnt = 16'hFFFF;
        cyc(1'b1, I_LW,  32'h300, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, I_ADD, 32'h2,   32'h2, 1'b0, 1'b0);
        cyc(1'b1, I_ADD, 32'h2,   32'h2, 1'b0, 1'b0);

        // Asynchronous reset asserted mid-cycle with a valid instruction in EX
        cyc(1'b1, I_ADDI, 32'h10, 32'h0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        check_val("pre_rst_valid", Ex_Valid, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("async_rst_valid",  Ex_Valid, 1'b0);
        check_val("async_rst_bubble", Bubble_Count, 16'd0);
        check_val("async_rst_pc",     Ex_PC, 32'd0);
        check_val("async_rst_rd1",    Ex_Read_Data1, 32'd0);
        check_val("async_rst_imm",    Ex_Imm, 32'd0);
        check_val("async_rst_memrd",  Ex_MemRead, 1'b0);
        @(negedge Clock);
        Reset_n = 1'b1;
        m = model_reset();
        exp_q.delete();

        // First capture after reset release
        cyc(1'b1, I_ORI, 32'h1, 32'h2, 1'b0, 1'b0);
        cyc(1'b1, I_LW,  32'h4, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, I_ADD, 32'h5, 32'h5, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage. It sits between the IF/ID latch and the EX stage, directly downstream of the 32x32 register file.
- Splits the incoming MIPS instruction into rs/rt/rd/shamt/funct/opcode and drives rs/rt to the register-file read ports.
- Registers the operands, sign- or zero-extended immediate and fields for EX.
- Detects load-use hazards, inserts bubbles, and counts them.

Parameters:
DATA_WIDTH, 32, operand/PC/instruction width
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 16, width of saturating bubble counter

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous active-low reset
If_Valid  in  1  IF/ID holds a valid instruction
If_Instruction  in  32  instruction from IF/ID
If_PC  in  32  PC+4 from IF/ID
Read_Register1  out  5  rs to register file (combinational from If_Instruction[25:21])
Read_Register2  out  5  rt to register file (combinational from If_Instruction[20:16])
Read_Data1  in  32  register file rs data, stable before Clock rise
Read_Data2  in  32  register file rt data, stable before Clock rise
Wb_RegWrite  in  1  writeback write enable
Wb_Write_Register  in  5  writeback destination
Wb_Write_Data  in  32  writeback data
Ex_Stall  in  1  EX cannot accept; hold stage
Flush  in  1  kill instruction entering EX (branch/jump taken)
Hazard_Stall  out  1  load-use hazard; IF/ID and PC must hold
Ex_Valid  out  1  EX-side contents valid
Ex_PC  out  32  registered If_PC
Ex_Read_Data1  out  32  registered rs operand
Ex_Read_Data2  out  32  registered rt operand
Ex_Imm  out  32  registered extended immediate
Ex_Rs, Ex_Rt, Ex_Rd  out  5 each  registered fields
Ex_Shamt  out  5  registered shamt
Ex_Opcode, Ex_Funct  out  6 each  registered opcode/funct
Ex_MemRead  out  1  registered (opcode == 6'h23)
Bubble_Count  out  CNT_WIDTH  saturating count of hazard bubbles

Behaviour:
- Reset (Reset_n low, asynchronous): all Ex_* outputs and Bubble_Count go to 0. Ex_Valid=0.
- Hazard_Stall (combinational): asserted when all of these hold:
  - Ex_Valid & Ex_MemRead & If_Valid & Ex_Rt != 0
  - Ex_Rt == If rs, or Ex_Rt == If rt
  - Hazard_Stall is forced 0 while Ex_Stall=1 or Flush=1.
- Update priority on Clock rise:
  1. Flush: Ex_Valid <= 0; other Ex_* hold.
  2. else Ex_Stall: every register holds.
  3. else Hazard_Stall: bubble. Ex_Valid <= 0, other Ex_* hold, Bubble_Count += 1, saturating at all-ones.
  4. else capture: Ex_Valid <= If_Valid and all fields load from the current IF/ID contents.
- Operand zero rule: if rs == 0 the captured operand is 0 regardless of Read_Data1. Same for rt.
- Immediate extension:
  - zero-extend If_Instruction[15:0] for opcodes 6'h0C (andi), 6'h0D (ori), 6'h0E (xori);
  - sign-extend for every other opcode.
- Fields are captured even when If_Valid=0. Only Ex_Valid qualifies them.
- Reset released mid-stream: the first capture happens on the first Clock rise with Reset_n high.
- Hazard resolution: the bubble ages the load out of the stage, so Hazard_Stall is never high for two consecutive unstalled cycles from the same load.

Optional Feature:
ID_EX_WB_BYPASS_EN
- Defined: when Wb_RegWrite=1, Wb_Write_Register != 0 and Wb_Write_Register == rs, the captured rs operand is Wb_Write_Data instead of Read_Data1. Same for rt. The zero rule still has priority.
- Undefined: operands always come from Read_Data1/2. Same-cycle write/read ordering is the register file's responsibility.

Decomposition:
Shared package (mips_pkg):
- opcode constants OP_RTYPE, OP_LW=6'h23, OP_SW=6'h2B, OP_ANDI, OP_ORI, OP_XORI
- field bit-position constants
- DATA_WIDTH / REG_ADDR_WIDTH defaults

Sub-module: hazard_unit (combinational load-use compare producing Hazard_Stall).

Test Plan:
1. Reset: assert Reset_n low mid-cycle with Ex_Valid=1 -> all outputs 0 immediately; Bubble_Count=0.
2. Capture: capture addi $t1,$t0,-4 (32'h2109FFFC) with Read_Data1=32'h10 -> Ex_Valid=1, Ex_Rs=8, Ex_Rt=9, Ex_Imm=32'hFFFFFFFC, Ex_Read_Data1=32'h10. Then ori with imm 16'h8000 -> Ex_Imm=32'h00008000.
3. Load-use: lw $t1,0($t0) then add $t2,$t1,$t1 -> Hazard_Stall=1 for exactly one cycle, Ex_Valid=0 that cycle, Bubble_Count=1; next cycle add captured with Ex_Valid=1.
4. Priority: Flush and Ex_Stall both high with a valid instruction -> Ex_Valid=0. Ex_Stall alone -> all Ex_* unchanged for 3 cycles. A load-use pair under Ex_Stall -> Hazard_Stall=0.
5. Register zero: rs=0 with Read_Data1=32'hDEADBEEF -> Ex_Read_Data1=0. Force Bubble_Count to 16'hFFFF, then cause a hazard -> Bubble_Count stays 16'hFFFF.
6. Bypass (ID_EX_WB_BYPASS_EN): Wb writes 32'hCAFE0001 to $t0 while add reads $t0 with stale Read_Data1=0 -> Ex_Read_Data1=32'hCAFE0001. Without the macro -> Ex_Read_Data1=0.
